axis_frame_fifo: RTL and testbench

- Single-clock AXI-Stream FIFO that stores and forwards whole frames, with tkeep support.
- A frame becomes visible at the output only after its tlast beat has been written. Frames marked bad (tuser on tlast) or frames that overflow the buffer are discarded at the input side.
- Sits between MAC/packet sources and consumers that must never see partial or errored frames. It is the same-clock, frame-aware successor to the async stream FIFO.

---
 rtl/axis_frame_fifo.sv | 180 ++++++++++++++++++
 tb/tb_axis_frame_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo.sv
// Single-clock AXI-Stream frame FIFO: a frame becomes readable only after its tlast
// beat commits, so bad or oversized frames are discarded before any beat is visible.
module axis_frame_fifo #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
  parameter int DROP_WHEN_FULL = 0,
  parameter int DROP_BAD_FRAME = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,

  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
);

  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 2;
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(2 ** ADDR_WIDTH);
  localparam bit DWF = (DROP_WHEN_FULL != 0);
  localparam bit DBF = (DROP_BAD_FRAME != 0);

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_DROP   = 1'b1
  } wr_state_t;

  wr_state_t         state, state_nxt;

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]  wr_ptr_cur, wr_ptr_cur_nxt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  fill;

  logic              full, empty;
  logic              in_ready, in_xfer;
  logic              mem_we;
  logic              rd_en;

  logic              good_nxt, bad_nxt, ovf_nxt;
  logic              good_p1, bad_p1, ovf_p1;

  logic [WORD_W-1:0] out_word_p1;
  logic              out_vld_p1;

  // full counts uncommitted beats so an in-progress frame cannot overrun unread data
  assign fill     = wr_ptr_cur - rd_ptr;
  assign full     = (fill == DEPTH_PTR);
  assign empty    = (rd_ptr == wr_ptr);
  assign in_ready = ~rst & (~full | DWF | (state == ST_DROP));
  assign in_xfer  = input_axis_tvalid & in_ready;

  assign input_axis_tready = in_ready;

  // ---- stage p0: write-side frame control ----
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    wr_ptr_cur_nxt = wr_ptr_cur;
    mem_we         = 1'b0;
    good_nxt       = 1'b0;
    bad_nxt        = 1'b0;
    ovf_nxt        = 1'b0;

    case (state)
      ST_ACCEPT: begin
        if (input_axis_tvalid) begin
          if (!full) begin
            if (in_xfer) begin
              mem_we         = 1'b1;
              wr_ptr_cur_nxt = wr_ptr_cur + 1'b1;
              if (input_axis_tlast) begin
                if (DBF && input_axis_tuser) begin
                  wr_ptr_cur_nxt = wr_ptr;
                  bad_nxt        = 1'b1;
                end else begin
                  wr_ptr_nxt = wr_ptr_cur + 1'b1;
                  good_nxt   = 1'b1;
                end
              end
            end
          end else if (DWF || (wr_ptr == rd_ptr)) begin
            // Frame cannot fit: rewind and swallow the rest. A tlast beat taken
            // here already ends the frame, so there is nothing left to drop.
            wr_ptr_cur_nxt = wr_ptr;
            ovf_nxt        = 1'b1;
            if (!(in_xfer && input_axis_tlast)) begin
              state_nxt = ST_DROP;
            end
          end
        end
      end

      ST_DROP: begin
        if (in_xfer && input_axis_tlast) begin
          state_nxt = ST_ACCEPT;
        end
      end

      default: state_nxt = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACCEPT;
      wr_ptr     <= '0;
      wr_ptr_cur <= '0;
      good_p1    <= 1'b0;
      bad_p1     <= 1'b0;
      ovf_p1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      wr_ptr_cur <= wr_ptr_cur_nxt;
      good_p1    <= good_nxt;
      bad_p1     <= bad_nxt;
      ovf_p1     <= ovf_nxt;
    end
  end

  // tuser is only meaningful downstream when bad frames are kept
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {input_axis_tlast, input_axis_tuser & ~DBF,
                                          input_axis_tkeep, input_axis_tdata};
    end
  end

  assign status_good_frame = good_p1;
  assign status_bad_frame  = bad_p1;
  assign status_overflow   = ovf_p1;

  // ---- stage p1: output register ----
  assign rd_en = (output_axis_tready | ~out_vld_p1) & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      out_vld_p1 <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (output_axis_tready | ~out_vld_p1) begin
        out_vld_p1 <= ~empty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      out_word_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  assign output_axis_tvalid = out_vld_p1;
  assign output_axis_tdata  = out_word_p1[DATA_WIDTH-1:0];
  assign output_axis_tkeep  = out_word_p1[DATA_WIDTH +: KEEP_WIDTH];
  assign output_axis_tuser  = out_word_p1[DATA_WIDTH + KEEP_WIDTH];
  assign output_axis_tlast  = out_word_p1[DATA_WIDTH + KEEP_WIDTH + 1];

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo (depth 8, backpressure on full, bad frames dropped):
// table-driven frames, hand-written corner sequences and a randomized scoreboard run.
module tb_axis_frame_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic [0:0] in_keep;
  logic       in_valid, in_ready, in_last, in_user;
  logic [7:0] out_data;
  logic [0:0] out_keep;
  logic       out_valid, out_ready, out_last, out_user;
  logic       st_ovf, st_bad, st_good;

  axis_frame_fifo #(
    .ADDR_WIDTH    (3),
    .DATA_WIDTH    (8),
    .KEEP_WIDTH    (1),
    .DROP_WHEN_FULL(0),
    .DROP_BAD_FRAME(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .input_axis_tdata  (in_data),
    .input_axis_tkeep  (in_keep),
    .input_axis_tvalid (in_valid),
    .input_axis_tready (in_ready),
    .input_axis_tlast  (in_last),
    .input_axis_tuser  (in_user),
    .output_axis_tdata (out_data),
    .output_axis_tkeep (out_keep),
    .output_axis_tvalid(out_valid),
    .output_axis_tready(out_ready),
    .output_axis_tlast (out_last),
    .output_axis_tuser (out_user),
    .status_overflow   (st_ovf),
    .status_bad_frame  (st_bad),
    .status_good_frame (st_good)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt_good = 0, cnt_bad = 0, cnt_ovf = 0;
  int g0, b0, o0;
  bit rand_done;

  // beat word: {tlast, tuser, tkeep, tdata}
  logic [10:0] got[$];
  logic [10:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got.push_back({out_last, out_user, out_keep, out_data});
      cnt_good += int'(st_good);
      cnt_bad  += int'(st_bad);
      cnt_ovf  += int'(st_ovf);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic k, input logic l,
                           input logic u, input int budget);
    logic rdy;
    int   n;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_user  = u;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < budget);
    in_valid = 1'b0;
    chk($sformatf("accept beat %0h", d), 32'(rdy), 32'd1);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic k, input logic l);
    exp_q.push_back({l, 1'b0, k, d});
  endtask

  task automatic check_stream(input string name, input int budget);
    int n = 0;
    while (got.size() < exp_q.size() && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    chk({name, " beat count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s beat %0d", name, i), 32'(got[i]), 32'(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic snap();
    g0 = cnt_good;
    b0 = cnt_bad;
    o0 = cnt_ovf;
  endtask

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       l;
    logic       u;
    logic       emit;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{d: 8'h11, k: 1'b1, l: 1'b0, u: 1'b0, emit: 1'b1};
    tbl[1] = '{d: 8'h22, k: 1'b1, l: 1'b0, u: 1'b0, emit: 1'b1};
    tbl[2] = '{d: 8'h33, k: 1'b1, l: 1'b1, u: 1'b0, emit: 1'b1};
    tbl[3] = '{d: 8'hA0, k: 1'b1, l: 1'b0, u: 1'b0, emit: 1'b0};
    tbl[4] = '{d: 8'hA1, k: 1'b0, l: 1'b1, u: 1'b1, emit: 1'b0};
    tbl[5] = '{d: 8'hB0, k: 1'b0, l: 1'b1, u: 1'b0, emit: 1'b1};
    tbl[6] = '{d: 8'hC0, k: 1'b1, l: 1'b0, u: 1'b1, emit: 1'b1};
    tbl[7] = '{d: 8'hC1, k: 1'b0, l: 1'b1, u: 1'b0, emit: 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0;
    in_last = 1'b0; in_user = 1'b0; out_ready = 1'b0;

    // reset state
    repeat (3) step();
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset status", 32'({st_ovf, st_bad, st_good}), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle in_ready", 32'(in_ready), 32'd1);

    // table: good, bad and good frames with latency check on the first one
    out_ready = 1'b1;
    snap();
    for (int i = 0; i < 8; i++) begin
      send_beat(tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].u, 20);
      chk($sformatf("row %0d good pulse", i), 32'(st_good), 32'(tbl[i].l & tbl[i].emit));
      chk($sformatf("row %0d bad pulse", i), 32'(st_bad), 32'(tbl[i].l & ~tbl[i].emit));
      if (tbl[i].emit) push_exp(tbl[i].d, tbl[i].k, tbl[i].l);
      if (i == 2) begin
        chk("latency +1 valid", 32'(out_valid), 32'd0);
        step();
        chk("latency +2 valid", 32'(out_valid), 32'd1);
        chk("latency +2 data", 32'(out_data), 32'h11);
      end
    end
    check_stream("table", 100);
    chk("table good count", 32'(cnt_good - g0), 32'd3);
    chk("table bad count", 32'(cnt_bad - b0), 32'd1);

    // backpressure: 8 entries plus the output register hold 9 beats
    out_ready = 1'b0;
    for (int idx = 0; idx < 12; idx++) begin
      logic [7:0] d;
      d = 8'(8'h31 + 8'h10 * (idx / 4) + (idx % 4));
      if (idx == 9) begin
        in_data = d; in_keep = 1'b1; in_last = 1'b0; in_user = 1'b0; in_valid = 1'b1;
        repeat (3) step();
        chk("bp stalled in_ready", 32'(in_ready), 32'd0);
        chk("bp held valid", 32'(out_valid), 32'd1);
        chk("bp held data", 32'(out_data), 32'h31);
        out_ready = 1'b1;
      end
      send_beat(d, 1'b1, (idx % 4) == 3, 1'b0, 50);
      push_exp(d, 1'b1, (idx % 4) == 3);
    end
    check_stream("backpressure", 200);

    // single frame longer than the whole buffer
    snap();
    for (int i = 0; i < 10; i++) begin
      send_beat(8'(8'h90 + i), 1'b1, i == 9, 1'b0, 20);
      if (i == 7) chk("ovf before 9th", 32'(cnt_ovf - o0), 32'd0);
      if (i == 8) chk("ovf on 9th", 32'(cnt_ovf - o0), 32'd1);
    end
    send_beat(8'h5A, 1'b1, 1'b1, 1'b0, 20);
    push_exp(8'h5A, 1'b1, 1'b1);
    check_stream("oversize", 100);
    chk("oversize ovf count", 32'(cnt_ovf - o0), 32'd1);
    chk("oversize good count", 32'(cnt_good - g0), 32'd1);

    // reset with a committed frame waiting and a partial frame in progress
    out_ready = 1'b0;
    send_beat(8'h66, 1'b1, 1'b1, 1'b0, 20);
    repeat (3) step();
    chk("pre-reset valid", 32'(out_valid), 32'd1);
    send_beat(8'h61, 1'b1, 1'b0, 1'b0, 20);
    send_beat(8'h62, 1'b1, 1'b0, 1'b0, 20);
    rst = 1'b1;
    #1;
    chk("in reset in_ready", 32'(in_ready), 32'd0);
    step();
    chk("after reset valid", 32'(out_valid), 32'd0);
    chk("after reset status", 32'({st_ovf, st_bad, st_good}), 32'd0);
    rst = 1'b0;
    snap();
    out_ready = 1'b1;
    send_beat(8'h77, 1'b1, 1'b1, 1'b0, 20);
    push_exp(8'h77, 1'b1, 1'b1);
    check_stream("reset", 100);
    chk("reset good count", 32'(cnt_good - g0), 32'd1);

    // random frames against a good-frame scoreboard
    begin
      int n_good = 0, n_bad = 0;
      snap();
      rand_done = 1'b0;
      fork
        begin
          for (int f = 0; f < 500; f++) begin
            int  len;
            bit  is_bad;
            len    = int'($urandom_range(1, 6));
            is_bad = ($urandom_range(0, 4) == 0);
            if (is_bad) n_bad++; else n_good++;
            for (int b = 0; b < len; b++) begin
              logic [7:0] d;
              logic       k, l, u;
              d = 8'($urandom);
              k = 1'($urandom);
              l = (b == len - 1);
              u = l ? is_bad : 1'($urandom);
              send_beat(d, k, l, u, 200);
              if (!is_bad) push_exp(d, k, l);
              repeat ($urandom_range(0, 2) == 0 ? 1 : 0) step();
            end
          end
          rand_done = 1'b1;
        end
        begin
          while (!rand_done) begin
            out_ready = ($urandom_range(0, 3) != 0);
            step();
          end
        end
      join
      out_ready = 1'b1;
      check_stream("random", 5000);
      chk("random good count", 32'(cnt_good - g0), 32'(n_good));
      chk("random bad count", 32'(cnt_bad - b0), 32'(n_bad));
      chk("random ovf count", 32'(cnt_ovf - o0), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
